conv_layer_sequencer: RTL
=========================

Name: conv_layer_sequencer

Overview:
Control FSM that sequences the two-layer CONV engine over a 64x64 greyscale image.
- Layer 0: 3x3 convolution with zero padding. Reads from image ROM, issues MAC strobes, writes results to L0 memory.
- Layer 1: 2x2 max-pool from L0 to L1.
- Generates all addresses, read/write strobes, csel and datapath control. The MAC/ReLU/max datapath and cdata_wr are outside this block.

Parameters:
IMG_W, 64, image width in pixels (power of 2)
IMG_H, 64, image height in pixels
ADDR_W, 12, address width of iaddr/caddr_rd/caddr_wr

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
ready  in  1  start request, sampled only in IDLE
busy  out  1  high while a frame is in progress
iaddr  out  ADDR_W  image ROM address; idata valid on the following rising edge
crd  out  1  L0 read strobe; cdata_rd valid on the following rising edge
caddr_rd  out  ADDR_W  L0 read address
cwr  out  1  write strobe (L0 or L1 per csel)
caddr_wr  out  ADDR_W  write address
csel  out  3  memory select: 3'b000 none, 3'b001 L0, 3'b011 L1
tap_idx  out  4  kernel weight index 0..8, aligned with idata
pad_zero  out  1  current idata tap is outside the image; datapath substitutes 0
mac_clr  out  1  load accumulator with this tap (first tap) instead of adding
mac_en  out  1  accumulate tap this cycle
max_clr  out  1  load pool register (first of 4)
max_en  out  1  compare/update pool register this cycle

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; pixel/tap counters 0. Applies mid-frame: abort, no further writes.
- States: IDLE -> CONV_RD -> CONV_DRAIN -> CONV_WR -> (next pixel CONV_RD | POOL_RD) ; POOL_RD -> POOL_DRAIN -> POOL_WR -> (next POOL_RD | IDLE).
- IDLE: if ready==1 go to CONV_RD, busy=1 from the next cycle. ready is ignored while busy.
- CONV_RD, 9 cycles, k=0..8: dy=k/3-1, dx=k%3-1.
  - In range: iaddr=(y+dy)*IMG_W+(x+dx).
  - Out of range: iaddr=0 and the registered pad flag=1.
- Data path alignment: tap_idx, pad_zero and mac_en are registered one cycle after the address. mac_clr accompanies tap 0.
- CONV_DRAIN, 1 cycle: last tap's mac_en.
- CONV_WR, 1 cycle: cwr=1, csel=001, caddr_wr=y*IMG_W+x. Raster advance x first; after (63,63) go to POOL_RD.
- Conv cost: 11 cycles per pixel, 45056 for the layer.
- POOL_RD, 4 cycles: crd=1, csel=001.
  - caddr_rd order: (2py,2px), (2py,2px+1), (2py+1,2px), (2py+1,2px+1).
  - max_en registered +1 cycle; max_clr with the first read.
- POOL_DRAIN, 1 cycle: last max_en.
- POOL_WR, 1 cycle: cwr=1, csel=011, caddr_wr=py*(IMG_W/2)+px. After (31,31) go to IDLE.
- Pool cost: 6 cycles per output, 6144 for the layer.
- busy: high from the cycle after ready is accepted through the final L1 write cycle inclusive, i.e. 51200 cycles, then 0.
- csel=000 in IDLE, CONV_RD and CONV_DRAIN. cwr and crd are never both 1. All outputs are registered.
- Counters: x,y 6 bits; px,py 5 bits; tap 4 bits. No wrap beyond the image; the terminal compare drives the state change.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, CONV_RD, CONV_DRAIN, CONV_WR, POOL_RD, POOL_DRAIN, POOL_WR)
  - CSEL_NONE/CSEL_L0/CSEL_L1 constants
  - IMG_W/IMG_H defaults
  - tap dx/dy offset constants
- One sub-module conv_tap_addr_gen: combinational (x,y,k) -> address plus out-of-range flag. Reused for the pool address (k restricted to 2x2).

Test Plan:
- Reset low for 2 cycles, then high, ready=0 -> all outputs 0, stays IDLE indefinitely.
- ready pulse 1 cycle -> busy=1 next cycle.
  - Pixel (0,0) taps: iaddr 0,0,0,0,0,1,0,64,65.
  - pad_zero registered sequence 1,1,1,1,0,0,1,0,0.
  - First cwr at cycle 11 with caddr_wr=0, csel=001.
- Pixel (63,63) taps -> pad on k=2,5,6,7,8. Write caddr_wr=4095. Next cycle POOL_RD with caddr_rd 0,1,64,65 and crd=1.
- Full frame -> exactly 4096 L0 writes and 1024 L1 writes.
  - Last L1 caddr_wr=1023, csel=011.
  - busy high for exactly 51200 cycles; cwr/crd never overlap.
- reset=0 during pixel (10,5) mid-CONV_RD -> next cycle busy=0, no cwr. A new ready restarts at pixel (0,0).
- ready held high throughout the frame -> no restart mid-frame. A second frame begins the cycle after return to IDLE.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the two-layer CONV sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE, CONV_RD, CONV_DRAIN, CONV_WR, POOL_RD, POOL_DRAIN, POOL_WR
  } state_t;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int IMG_W_DEF  = 64;
  localparam int IMG_H_DEF  = 64;
  localparam int ADDR_W_DEF = 12;

  localparam int NUM_TAPS  = 9;
  localparam int POOL_TAPS = 4;

  // Tap k covers offset (dx,dy) = (k%3-1, k/3-1), raster order over the 3x3 window.
  localparam logic signed [1:0] TAP_DX [NUM_TAPS] =
    '{-2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
  localparam logic signed [1:0] TAP_DY [NUM_TAPS] =
    '{-2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

  // Pool read q=0..3 reuses the lower-right 2x2 of the 3x3 window: taps 4,5,7,8.
  function automatic logic [3:0] pool_tap(input logic [1:0] q);
    return 4'd4 + {2'b00, q} + {3'b000, q[1]};
  endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Combinational (x,y,tap) -> linear address with out-of-image flag; address is 0 when outside.
module conv_tap_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              oor
);

  logic [3:0]           ks;
  logic signed [XW+1:0] xs;
  logic signed [YW+1:0] ys;

  always_comb begin
    ks   = (k < 4'(NUM_TAPS)) ? k : 4'd4;
    xs   = $signed({2'b00, x}) + (XW+2)'(TAP_DX[ks]);
    ys   = $signed({2'b00, y}) + (YW+2)'(TAP_DY[ks]);
    // Sign bit catches -1; the unsigned compare catches one-past-the-edge.
    oor  = xs[XW+1] | (xs[XW:0] >= (XW+1)'(IMG_W)) |
           ys[YW+1] | (ys[YW:0] >= (YW+1)'(IMG_H));
    addr = oor ? '0 : ADDR_W'({ys[YW-1:0], xs[XW-1:0]});
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Control FSM for a 3x3 zero-padded conv layer (image ROM -> L0) followed by 2x2 max-pool (L0 -> L1).
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [2:0]        csel,
  output logic [3:0]        tap_idx,
  output logic              pad_zero,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              max_clr,
  output logic              max_en
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int PXW = XW - 1;
  localparam int PYW = YW - 1;

  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
  localparam logic [PXW-1:0] PX_LAST   = PXW'(IMG_W / 2 - 1);
  localparam logic [PYW-1:0] PY_LAST   = PYW'(IMG_H / 2 - 1);
  localparam logic [3:0]     TAP_LAST  = 4'(NUM_TAPS - 1);
  localparam logic [3:0]     POOL_LAST = 4'(POOL_TAPS - 1);

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [PXW-1:0] px_q, px_d;
  logic [PYW-1:0] py_q, py_d;
  logic [3:0]     tap_q, tap_d;

  logic [ADDR_W-1:0] tap_addr, pool_addr;
  logic              tap_oor, pool_oor;
  logic              pad_pre;

  // Address generators look at the next-state counters so the address registers
  // line up with the state being entered.
  conv_tap_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_tap_addr (
    .x(x_d), .y(y_d), .k(tap_d), .addr(tap_addr), .oor(tap_oor)
  );

  conv_tap_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_pool_addr (
    .x({px_d, 1'b0}), .y({py_d, 1'b0}), .k(pool_tap(tap_d[1:0])),
    .addr(pool_addr), .oor(pool_oor)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tap_q   <= tap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    tap_d   = tap_q;
    unique case (state_q)
      IDLE: begin
        if (ready) begin
          state_d = CONV_RD;
          x_d     = '0;
          y_d     = '0;
          px_d    = '0;
          py_d    = '0;
          tap_d   = '0;
        end
      end
      CONV_RD: begin
        if (tap_q == TAP_LAST) state_d = CONV_DRAIN;
        else                   tap_d   = tap_q + 4'd1;
      end
      CONV_DRAIN: state_d = CONV_WR;
      CONV_WR: begin
        tap_d   = '0;
        state_d = CONV_RD;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) state_d = POOL_RD;
          else               y_d     = y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      POOL_RD: begin
        if (tap_q == POOL_LAST) state_d = POOL_DRAIN;
        else                    tap_d   = tap_q + 4'd1;
      end
      POOL_DRAIN: state_d = POOL_WR;
      POOL_WR: begin
        tap_d   = '0;
        state_d = POOL_RD;
        if (px_q == PX_LAST) begin
          px_d = '0;
          if (py_q == PY_LAST) state_d = IDLE;
          else                 py_d    = py_q + 1'b1;
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/strobe outputs decode the incoming state; datapath controls decode the
  // current state, landing one cycle later alongside the memory data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b0;
      iaddr    <= '0;
      pad_pre  <= 1'b0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      csel     <= CSEL_NONE;
      tap_idx  <= '0;
      pad_zero <= 1'b0;
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      max_clr  <= 1'b0;
      max_en   <= 1'b0;
    end else begin
      busy     <= (state_d != IDLE);
      iaddr    <= (state_d == CONV_RD) ? tap_addr : '0;
      pad_pre  <= (state_d == CONV_RD) && tap_oor;
      crd      <= (state_d == POOL_RD) && !pool_oor;
      caddr_rd <= (state_d == POOL_RD) ? pool_addr : '0;
      cwr      <= (state_d == CONV_WR) || (state_d == POOL_WR);
      case (state_d)
        CONV_WR: begin
          csel     <= CSEL_L0;
          caddr_wr <= ADDR_W'({y_d, x_d});
        end
        POOL_RD, POOL_DRAIN: begin
          csel     <= CSEL_L0;
          caddr_wr <= '0;
        end
        POOL_WR: begin
          csel     <= CSEL_L1;
          caddr_wr <= ADDR_W'({py_d, px_d});
        end
        default: begin
          csel     <= CSEL_NONE;
          caddr_wr <= '0;
        end
      endcase
      tap_idx  <= (state_q == CONV_RD) ? tap_q : '0;
      pad_zero <= pad_pre;
      mac_en   <= (state_q == CONV_RD);
      mac_clr  <= (state_q == CONV_RD) && (tap_q == '0);
      max_en   <= (state_q == POOL_RD);
      max_clr  <= (state_q == POOL_RD) && (tap_q == '0);
    end
  end

endmodule
